// File: rtl/bsg_cache_sbuf_deep_if.sv
// ---------------------------------------------------------------------------
// bsg_cache_sbuf_deep_if
//
// Bundles the store-buffer traffic into one interface:
//   enqueue side : v_i, ready_o, addr_i, data_i, mask_i
//   head side    : v_o, yumi_i, addr_o, data_o, mask_o
//   bypass side  : bypass_v_i, bypass_addr_i, bypass_data_o, bypass_mask_o
// Signal suffixes are from the buffer's point of view.
//
// Handshakes:
//   enqueue - an entry transfers on a rising edge where v_i & ready_o;
//             ready_o may depend combinationally on yumi_i and addr_i.
//   head    - v_o/addr_o/data_o/mask_o describe the oldest entry; the
//             consumer raises yumi_i only while v_o is 1 and the entry
//             leaves on that edge.
//
// Modports: master = producer/consumer/load side, slave = the buffer.
// ---------------------------------------------------------------------------
interface bsg_cache_sbuf_deep_if #(
    parameter int addr_width_p = 28,
    parameter int data_width_p = 32
);
    localparam int mask_width_lp = data_width_p / 8;

    logic                     v_i;
    logic                     ready_o;
    logic [addr_width_p-1:0]  addr_i;
    logic [data_width_p-1:0]  data_i;
    logic [mask_width_lp-1:0] mask_i;

    logic                     v_o;
    logic                     yumi_i;
    logic [addr_width_p-1:0]  addr_o;
    logic [data_width_p-1:0]  data_o;
    logic [mask_width_lp-1:0] mask_o;

    logic                     bypass_v_i;
    logic [addr_width_p-1:0]  bypass_addr_i;
    logic [data_width_p-1:0]  bypass_data_o;
    logic [mask_width_lp-1:0] bypass_mask_o;

    modport master (
        output v_i, addr_i, data_i, mask_i, yumi_i, bypass_v_i, bypass_addr_i,
        input  ready_o, v_o, addr_o, data_o, mask_o, bypass_data_o, bypass_mask_o
    );

    modport slave (
        input  v_i, addr_i, data_i, mask_i, yumi_i, bypass_v_i, bypass_addr_i,
        output ready_o, v_o, addr_o, data_o, mask_o, bypass_data_o, bypass_mask_o
    );
endinterface

// File: rtl/bsg_cache_sbuf_deep.sv
// ---------------------------------------------------------------------------
// bsg_cache_sbuf_deep
//
// Store buffer of els_p entries between the tag-lookup stage and the data
// array write port. Entries are held in a circular array of
// {word address, data, byte mask}. An empty buffer passes the incoming
// entry straight through to the head outputs. A 1-cycle registered load
// bypass merges every buffered store plus the store accepted this cycle,
// youngest store winning per byte.
//
// Optional feature: define BSG_CACHE_SBUF_DEEP_COALESCE_EN to merge an
// accepted store into the youngest stored entry when they share a word
// address (and that entry is not leaving this cycle).
//
// Ports:
//   clk_i      - clock, rising edge
//   reset_n_i  - asynchronous active-low reset
//   bus        - bsg_cache_sbuf_deep_if.slave (enqueue, head, bypass)
//   empty_o    - no stored entries
//   count_o    - stored entry count (0..els_p)
// Addresses on addr_o for stored entries are word aligned (low byte bits 0);
// in pass-through addr_o is addr_i unchanged.
// ---------------------------------------------------------------------------
module bsg_cache_sbuf_deep #(
    parameter int els_p        = 4,
    parameter int addr_width_p = 28,
    parameter int data_width_p = 32,
    localparam int mask_width_lp = data_width_p / 8,
    localparam int lg_els_lp     = $clog2(els_p + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    bsg_cache_sbuf_deep_if.slave bus,
    output logic                 empty_o,
    output logic [lg_els_lp-1:0] count_o
);

    localparam int lg_mask_lp     = $clog2(mask_width_lp);
    localparam int waddr_width_lp = addr_width_p - lg_mask_lp;
    localparam int ptr_width_lp   = $clog2(els_p);

    typedef logic [waddr_width_lp-1:0] waddr_t;
    typedef logic [ptr_width_lp-1:0]   ptr_t;
    typedef logic [ptr_width_lp:0]     ptr_wide_t;

    // Storage (no reset: only slots covered by count_q are ever observed)
    waddr_t                   waddr_q [els_p];
    logic [data_width_p-1:0]  data_q  [els_p];
    logic [mask_width_lp-1:0] mask_q  [els_p];

    ptr_t                     head_q, head_d;
    ptr_t                     tail_q, tail_d;
    logic [lg_els_lp-1:0]     count_q, count_d;
    logic [data_width_p-1:0]  byp_data_q, byp_data_d;
    logic [mask_width_lp-1:0] byp_mask_q, byp_mask_d;

    waddr_t in_waddr, byp_waddr;
    logic   empty, full, coalesce, ready, accept, pass_consume, enq, deq;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(els_p - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign in_waddr  = bus.addr_i[addr_width_p-1:lg_mask_lp];
    assign byp_waddr = bus.bypass_addr_i[addr_width_p-1:lg_mask_lp];

    if (lg_mask_lp > 0) begin : g_byp_low
        // Byte offset of the load address does not affect a word lookup.
        logic unused_byp_low;
        assign unused_byp_low = ^bus.bypass_addr_i[lg_mask_lp-1:0];
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == lg_els_lp'(els_p));

`ifdef BSG_CACHE_SBUF_DEEP_COALESCE_EN
    ptr_t                    tail_prev;
    logic [data_width_p-1:0] coal_data;

    // tail_q is the next free slot; the youngest stored entry sits just behind it.
    assign tail_prev = (tail_q == '0) ? ptr_t'(els_p - 1) : tail_q - ptr_t'(1);

    // With one entry the tail is also the head; if it is leaving this
    // cycle the new store must allocate instead of merging into it.
    assign coalesce = bus.v_i & ~empty
                    & (in_waddr == waddr_q[tail_prev])
                    & ~(bus.yumi_i & (count_q == lg_els_lp'(1)));

    always_comb begin
        coal_data = data_q[tail_prev];
        for (int b = 0; b < mask_width_lp; b++) begin
            if (bus.mask_i[b]) coal_data[8*b +: 8] = bus.data_i[8*b +: 8];
        end
    end
`else
    assign coalesce = 1'b0;
`endif

    assign ready        = ~full | bus.yumi_i | coalesce;
    assign accept       = bus.v_i & ready;
    // Empty buffer with the consumer taking the entry: it never lands in storage.
    assign pass_consume = empty & bus.yumi_i & bus.v_i;
    assign enq          = accept & ~pass_consume & ~coalesce;
    assign deq          = bus.yumi_i & ~empty;

    assign count_d = count_q + lg_els_lp'(enq) - lg_els_lp'(deq);
    assign head_d  = deq ? ptr_inc(head_q) : head_q;
    assign tail_d  = enq ? ptr_inc(tail_q) : tail_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            waddr_q[tail_q] <= in_waddr;
            data_q[tail_q]  <= bus.data_i;
            mask_q[tail_q]  <= bus.mask_i;
        end
`ifdef BSG_CACHE_SBUF_DEEP_COALESCE_EN
        else if (coalesce) begin
            data_q[tail_prev] <= coal_data;
            mask_q[tail_prev] <= mask_q[tail_prev] | bus.mask_i;
        end
`endif
    end

    // Head path
    assign bus.ready_o = ready;
    assign bus.v_o     = empty ? bus.v_i    : 1'b1;
    assign bus.addr_o  = empty ? bus.addr_i : (addr_width_p'(waddr_q[head_q]) << lg_mask_lp);
    assign bus.data_o  = empty ? bus.data_i : data_q[head_q];
    assign bus.mask_o  = empty ? bus.mask_i : mask_q[head_q];
    assign empty_o     = empty;
    assign count_o     = count_q;

    // Bypass merge: walk stored entries oldest to youngest so later hits
    // overwrite earlier ones byte by byte; the accepted input is applied last.
    ptr_wide_t slot_w;
    ptr_t      slot;

    always_comb begin
        byp_data_d = '0;
        byp_mask_d = '0;
        slot_w     = '0;
        slot       = '0;
        for (int i = 0; i < els_p; i++) begin
            slot_w = {1'b0, head_q} + ptr_wide_t'(i);
            if (slot_w >= ptr_wide_t'(els_p)) slot_w = slot_w - ptr_wide_t'(els_p);
            slot = slot_w[ptr_width_lp-1:0];
            if ((lg_els_lp'(i) < count_q) && (waddr_q[slot] == byp_waddr)) begin
                for (int b = 0; b < mask_width_lp; b++) begin
                    if (mask_q[slot][b]) begin
                        byp_data_d[8*b +: 8] = data_q[slot][8*b +: 8];
                        byp_mask_d[b]        = 1'b1;
                    end
                end
            end
        end
        if (accept && (in_waddr == byp_waddr)) begin
            for (int b = 0; b < mask_width_lp; b++) begin
                if (bus.mask_i[b]) begin
                    byp_data_d[8*b +: 8] = bus.data_i[8*b +: 8];
                    byp_mask_d[b]        = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            byp_data_q <= '0;
            byp_mask_q <= '0;
        end else if (bus.bypass_v_i) begin
            byp_data_q <= byp_data_d;
            byp_mask_q <= byp_mask_d;
        end
    end

    assign bus.bypass_data_o = byp_data_q;
    assign bus.bypass_mask_o = byp_mask_q;

endmodule
